decoder_3to8_strobe: RTL and testbench

- Sequential 3-to-8 line decoder and strobe driver. It is the companion of the 8-to-3 one-hot encoder.
- Accepts 3-bit codes over a valid/ready handshake and queues them in a small FIFO.
- Drives each code as a one-hot 8-bit line select, held for HOLD cycles, with GAP all-zero cycles between strobes.
- Used to sequence line selects (row enables, chip selects) from a code stream.

---
 rtl/decoder_3to8_strobe_if.sv | 24 ++
 rtl/decoder_3to8_strobe.sv | 153 +++++++++++++++
 tb/tb_decoder_3to8_strobe.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_3to8_strobe_if.sv
// Handshake and strobe-output bundle for decoder_3to8_strobe.
// The master side offers codes and the enable; the slave side is the decoder itself.
interface decoder_3to8_strobe_if #(
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic [2:0]               in_code;
  logic                     in_ready;
  logic                     en;
  logic [7:0]               out_onehot;
  logic                     out_busy;
  logic                     done_pulse;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output in_valid, in_code, en,
    input  in_ready, out_onehot, out_busy, done_pulse, fifo_count
  );

  modport slave (
    input  in_valid, in_code, en,
    output in_ready, out_onehot, out_busy, done_pulse, fifo_count
  );
endinterface

// File: rtl/decoder_3to8_strobe.sv
// Queued 3-to-8 decoder: codes enter a small FIFO and are driven out as one-hot
// strobes held HOLD cycles, separated by GAP all-zero cycles.
module decoder_3to8_strobe #(
  parameter int DEPTH = 4,
  parameter int HOLD  = 3,
  parameter int GAP   = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decoder_3to8_strobe_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [CW-1:0] FULL      = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_GAP
  } state_t;

  logic [2:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  state_t        state;
  state_t        state_n;
  logic [HW-1:0] hold_cnt;
  logic [HW-1:0] hold_n;
  logic [GW-1:0] gap_cnt;
  logic [GW-1:0] gap_n;
  logic [7:0]    out_q;
  logic [7:0]    out_n;
  logic          busy_q;

  logic          push;
  logic          pop;
  logic          can_pop;
  logic [2:0]    head;

  // in_ready looks only at the stored count, so a full FIFO refuses even when a pop is due.
  assign bus.in_ready   = (count != FULL);
  assign push           = bus.in_valid && bus.in_ready;
  assign can_pop        = (count != '0) && bus.en;
  assign head           = mem[rd_ptr];

  assign bus.out_onehot = out_q;
  assign bus.out_busy   = busy_q;
  assign bus.fifo_count = count;
  assign bus.done_pulse = (state == ST_DRIVE) && (hold_cnt == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.in_code;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      out_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= hold_n;
      gap_cnt  <= gap_n;
      out_q    <= out_n;
      busy_q   <= (state_n != ST_IDLE);
    end
  end

  // Every pop loads the output register in the same edge, so the line select never goes multi-hot.
  always_comb begin
    state_n = state;
    hold_n  = hold_cnt;
    gap_n   = gap_cnt;
    out_n   = out_q;
    pop     = 1'b0;
    case (state)
      ST_IDLE: begin
        out_n = '0;
        if (can_pop) begin
          pop     = 1'b1;
          out_n   = 8'd1 << head;
          hold_n  = HOLD_LOAD;
          state_n = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (hold_cnt != '0) begin
          hold_n = hold_cnt - HW'(1);
        end else if (GAP > 0) begin
          out_n   = '0;
          gap_n   = GAP_LOAD;
          state_n = ST_GAP;
        end else if (can_pop) begin
          pop    = 1'b1;
          out_n  = 8'd1 << head;
          hold_n = HOLD_LOAD;
        end else begin
          out_n   = '0;
          state_n = ST_IDLE;
        end
      end
      ST_GAP: begin
        out_n = '0;
        if (gap_cnt != '0) begin
          gap_n = gap_cnt - GW'(1);
        end else if (can_pop) begin
          pop     = 1'b1;
          out_n   = 8'd1 << head;
          hold_n  = HOLD_LOAD;
          state_n = ST_DRIVE;
        end else begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        out_n   = '0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_decoder_3to8_strobe.sv
// Drives a GAP=1 and a GAP=0 decoder with the same stimulus and compares both
// against a slot-based model of queue plus strobe timeline.
module tb_decoder_3to8_strobe;

  localparam int DEPTH = 4;
  localparam int HOLD  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid;
  logic [2:0] in_code;
  logic       en;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  decoder_3to8_strobe_if #(.DEPTH(DEPTH)) bus0 ();
  decoder_3to8_strobe_if #(.DEPTH(DEPTH)) bus1 ();

  assign bus0.in_valid = in_valid;
  assign bus0.in_code  = in_code;
  assign bus0.en       = en;
  assign bus1.in_valid = in_valid;
  assign bus1.in_code  = in_code;
  assign bus1.en       = en;

  decoder_3to8_strobe #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(1)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  decoder_3to8_strobe #(.DEPTH(DEPTH), .HOLD(HOLD), .GAP(0)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  logic [7:0] o_out   [2];
  logic       o_busy  [2];
  logic       o_done  [2];
  logic       o_ready [2];
  logic [2:0] o_cnt   [2];

  assign o_out[0]   = bus0.out_onehot;
  assign o_out[1]   = bus1.out_onehot;
  assign o_busy[0]  = bus0.out_busy;
  assign o_busy[1]  = bus1.out_busy;
  assign o_done[0]  = bus0.done_pulse;
  assign o_done[1]  = bus1.done_pulse;
  assign o_ready[0] = bus0.in_ready;
  assign o_ready[1] = bus1.in_ready;
  assign o_cnt[0]   = bus0.fifo_count;
  assign o_cnt[1]   = bus1.fifo_count;

  // Model: a code queue plus a position within the HOLD+GAP slot timeline of the active strobe.
  int mq [2][$];
  bit m_act  [2];
  int m_slot [2];
  int m_cur  [2];
  bit last_acc0;

  function automatic int gapOf(input int idx);
    return (idx == 0) ? 1 : 0;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mq[i].delete();
      m_act[i]  = 1'b0;
      m_slot[i] = 0;
      m_cur[i]  = 0;
    end
  endtask

  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      bit push_ok;
      bit can_pop;
      int last_slot;
      push_ok   = in_valid && (mq[i].size() != DEPTH);
      can_pop   = (mq[i].size() > 0) && en;
      last_slot = HOLD + gapOf(i) - 1;
      if (i == 0) last_acc0 = push_ok;
      if (!m_act[i]) begin
        if (can_pop) begin
          m_cur[i]  = mq[i].pop_front();
          m_act[i]  = 1'b1;
          m_slot[i] = 0;
        end
      end else if (m_slot[i] == last_slot) begin
        if (can_pop) begin
          m_cur[i]  = mq[i].pop_front();
          m_slot[i] = 0;
        end else begin
          m_act[i] = 1'b0;
        end
      end else begin
        m_slot[i]++;
      end
      if (push_ok) mq[i].push_back(int'(in_code));
    end
  endtask

  task automatic checkVal(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s dut%0d observed=%0h expected=%0h", tag, idx, obs, exp);
    end
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      logic [7:0] e_out;
      e_out = (m_act[i] && m_slot[i] < HOLD) ? (8'd1 << m_cur[i]) : 8'h00;
      checkVal("onehot", i, 32'(o_out[i]), 32'(e_out));
      checkVal("busy",   i, 32'(o_busy[i]), 32'(m_act[i]));
      checkVal("done",   i, 32'(o_done[i]), 32'(m_act[i] && m_slot[i] == HOLD - 1));
      checkVal("count",  i, 32'(o_cnt[i]), 32'(mq[i].size()));
      checkVal("ready",  i, 32'(o_ready[i]), 32'(mq[i].size() != DEPTH));
    end
  endtask

  task automatic applyStimulus(input bit v, input logic [2:0] c, input bit e);
    @(negedge clk);
    in_valid = v;
    in_code  = c;
    en       = e;
    @(posedge clk);
    modelEdge();
    #1;
    checkOutput();
  endtask

  task automatic idleCycles(input int n, input bit e);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 3'd0, e);
  endtask

  task automatic checkResetState(input string tag);
    for (int i = 0; i < 2; i++) begin
      checkVal({tag, "_onehot"}, i, 32'(o_out[i]), 32'h0);
      checkVal({tag, "_busy"},   i, 32'(o_busy[i]), 32'h0);
      checkVal({tag, "_done"},   i, 32'(o_done[i]), 32'h0);
      checkVal({tag, "_count"},  i, 32'(o_cnt[i]), 32'h0);
      checkVal({tag, "_ready"},  i, 32'(o_ready[i]), 32'h1);
    end
  endtask

  // Asserts reset between clock edges and checks outputs before any edge arrives.
  task automatic resetMid();
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checkResetState("async_reset");
    modelReset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [2:0] bp_codes [5];
    int c;
    bp_codes[0] = 3'd2;
    bp_codes[1] = 3'd4;
    bp_codes[2] = 3'd6;
    bp_codes[3] = 3'd1;
    bp_codes[4] = 3'd3;
    in_valid = 1'b0;
    in_code  = 3'd0;
    en       = 1'b0;
    modelReset();
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single code 5");
    applyStimulus(1'b1, 3'd5, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkVal("single_first_hold", 0, 32'(o_out[0]), 32'h20);
    applyStimulus(1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b1);
    checkVal("single_done", 0, 32'(o_done[0]), 32'h1);
    checkVal("single_last_hold", 0, 32'(o_out[0]), 32'h20);
    idleCycles(6, 1'b1);

    $display("[TB] burst 0..7");
    c = 0;
    for (int k = 0; k < 200 && c < 8; k++) begin
      applyStimulus(1'b1, 3'(c), 1'b1);
      if (last_acc0) c++;
    end
    idleCycles(40, 1'b1);

    $display("[TB] full and backpressure");
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, bp_codes[k], 1'b0);
    checkVal("full_count", 0, 32'(o_cnt[0]), 32'd4);
    checkVal("full_ready", 0, 32'(o_ready[0]), 32'h0);
    checkVal("full_count", 1, 32'(o_cnt[1]), 32'd4);
    last_acc0 = 1'b0;
    for (int k = 0; k < 100 && !last_acc0; k++) applyStimulus(1'b1, 3'd3, 1'b1);
    idleCycles(40, 1'b1);

    $display("[TB] enable drop during drive");
    applyStimulus(1'b1, 3'd7, 1'b0);
    applyStimulus(1'b1, 3'd1, 1'b0);
    applyStimulus(1'b1, 3'd5, 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    idleCycles(8, 1'b0);
    checkVal("en_drop_count", 0, 32'(o_cnt[0]), 32'd2);
    checkVal("en_drop_onehot", 0, 32'(o_out[0]), 32'h0);
    idleCycles(30, 1'b1);

    $display("[TB] reset during hold");
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 3'(k + 2), 1'b0);
    applyStimulus(1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 3'd0, 1'b0);
    resetMid();
    idleCycles(10, 1'b1);

    $display("[TB] back-to-back strobes without gap");
    applyStimulus(1'b1, 3'd0, 1'b0);
    applyStimulus(1'b1, 3'd7, 1'b0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b0, 3'd0, 1'b1);
      checkVal("gap0_onehot", 1, 32'(o_out[1]), (k < 3) ? 32'h01 : 32'h80);
      checkVal("gap0_done", 1, 32'(o_done[1]), 32'(k == 2 || k == 5));
    end
    idleCycles(20, 1'b1);

    $display("[TB] random traffic");
    for (int k = 0; k < 400; k++) begin
      applyStimulus(1'($urandom % 2), 3'($urandom % 8), 1'(($urandom % 4) != 0));
    end
    idleCycles(40, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
